// File: rtl/nc_store_pkg.sv
// Shared types, index lists and packing helpers for the CAVLC nC context store.
package nc_store_pkg;

  localparam int MB_X_BITS        = 7;
  localparam int PIC_W_MB_DEFAULT = 120;

  typedef enum logic [1:0] {
    COMP_LUMA = 2'd0,
    COMP_CB   = 2'd1,
    COMP_CR   = 2'd2,
    COMP_RSVD = 2'd3
  } comp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ACTIVE,
    ST_COMMIT
  } state_e;

  typedef logic [15:0][7:0] luma_arr_t;
  typedef logic [3:0][7:0]  chroma_arr_t;

  // Highest-numbered list element lands in the most significant byte of the packed word.
  localparam logic [3:0][3:0] LUMA_UP_IDX     = {4'd15, 4'd14, 4'd11, 4'd10};
  localparam logic [3:0][3:0] LUMA_LEFT_IDX   = {4'd15, 4'd13, 4'd7,  4'd5};
  localparam logic [1:0][1:0] CHROMA_UP_IDX   = {2'd3, 2'd2};
  localparam logic [1:0][1:0] CHROMA_LEFT_IDX = {2'd3, 2'd1};

  function automatic logic [31:0] pickLuma(input luma_arr_t blk, input logic [3:0][3:0] idx);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = blk[idx[k]];
    return r;
  endfunction

  function automatic logic [15:0] pickChroma(input chroma_arr_t blk, input logic [1:0][1:0] idx);
    logic [15:0] r;
    for (int k = 0; k < 2; k++) r[8*k +: 8] = blk[idx[k]];
    return r;
  endfunction

endpackage

// File: rtl/nc_store_if.sv
// Writer/reader bundle between the coeff_token parser, nc_store and nC prediction.
interface nc_store_if;

  logic                                start_of_pic_in;
  logic                                mb_start_in;
  logic [nc_store_pkg::MB_X_BITS-1:0]  mb_x_in;
  logic                                wr_en_in;
  logic [1:0]                          wr_comp_in;
  logic [3:0]                          wr_blk_idx_in;
  logic [4:0]                          total_coeff_in;
  logic                                mb_clear_in;
  logic                                mb_done_in;
  logic                                ready_out;
  logic [31:0]                         nC_up_mb_out;
  logic [31:0]                         nC_left_mb_out;
  logic [127:0]                        nC_curr_mb_out;
  logic [15:0]                         nC_cb_up_mb_out;
  logic [15:0]                         nC_cr_up_mb_out;
  logic [15:0]                         nC_cb_left_mb_out;
  logic [15:0]                         nC_cr_left_mb_out;
  logic [31:0]                         nC_cb_curr_mb_out;
  logic [31:0]                         nC_cr_curr_mb_out;

  modport master (
    output start_of_pic_in, mb_start_in, mb_x_in, wr_en_in, wr_comp_in,
           wr_blk_idx_in, total_coeff_in, mb_clear_in, mb_done_in,
    input  ready_out, nC_up_mb_out, nC_left_mb_out, nC_curr_mb_out,
           nC_cb_up_mb_out, nC_cr_up_mb_out, nC_cb_left_mb_out, nC_cr_left_mb_out,
           nC_cb_curr_mb_out, nC_cr_curr_mb_out
  );

  modport slave (
    input  start_of_pic_in, mb_start_in, mb_x_in, wr_en_in, wr_comp_in,
           wr_blk_idx_in, total_coeff_in, mb_clear_in, mb_done_in,
    output ready_out, nC_up_mb_out, nC_left_mb_out, nC_curr_mb_out,
           nC_cb_up_mb_out, nC_cr_up_mb_out, nC_cb_left_mb_out, nC_cr_left_mb_out,
           nC_cb_curr_mb_out, nC_cr_curr_mb_out
  );

endinterface

// File: rtl/nc_store_line_ram.sv
// Single-port line buffer of bottom-row TotalCoeff words; one-cycle read, write-first.
module nc_store_line_ram #(
  parameter int DEPTH = 120,
  parameter int AW    = 7,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Contents are deliberately not reset; the first write of each column defines them.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_q       <= wdata_i;
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/nc_store.sv
// nC context store: current-MB TotalCoeff array, left column registers and line-buffer
// of bottom rows, presented in the packed layout expected by nC prediction.
module nc_store
  import nc_store_pkg::*;
#(
  parameter int PIC_W_MB = PIC_W_MB_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  nc_store_if.slave bus
);

  state_e               state_q;
  logic [MB_X_BITS-1:0] mbX_q;
  logic                 ready_q;
  luma_arr_t            lumaCurr_q, lumaCurr_d;
  chroma_arr_t          cbCurr_q, cbCurr_d, crCurr_q, crCurr_d;
  logic [31:0]          lumaUp_q, lumaLeft_q;
  logic [15:0]          cbUp_q, crUp_q, cbLeft_q, crLeft_q;

  logic                 ramWe;
  logic [MB_X_BITS-1:0] ramAddr;
  logic [63:0]          ramWdata, ramRdata;
  logic [7:0]           wrEntry;

  assign wrEntry = {3'b000, bus.total_coeff_in};

  // A clear and a write in the same cycle: the write lands on the freshly cleared array.
  always_comb begin
    lumaCurr_d = lumaCurr_q;
    cbCurr_d   = cbCurr_q;
    crCurr_d   = crCurr_q;
    if (state_q == ST_IDLE && bus.mb_start_in) begin
      lumaCurr_d = '0;
      cbCurr_d   = '0;
      crCurr_d   = '0;
    end else if (state_q == ST_ACTIVE) begin
      if (bus.mb_clear_in) begin
        lumaCurr_d = '0;
        cbCurr_d   = '0;
        crCurr_d   = '0;
      end
      if (bus.wr_en_in) begin
        case (comp_e'(bus.wr_comp_in))
          COMP_LUMA: lumaCurr_d[bus.wr_blk_idx_in]    = wrEntry;
          COMP_CB:   cbCurr_d[bus.wr_blk_idx_in[1:0]] = wrEntry;
          COMP_CR:   crCurr_d[bus.wr_blk_idx_in[1:0]] = wrEntry;
          default:   ;
        endcase
      end
    end
  end

  // Reset during COMMIT must not leave a half-finished macroblock in the line buffer.
  assign ramWe    = (state_q == ST_COMMIT) && !rst;
  assign ramAddr  = (state_q == ST_COMMIT) ? mbX_q : bus.mb_x_in;
  assign ramWdata = {pickChroma(crCurr_q, CHROMA_UP_IDX),
                     pickChroma(cbCurr_q, CHROMA_UP_IDX),
                     pickLuma(lumaCurr_q, LUMA_UP_IDX)};

  nc_store_line_ram #(
    .DEPTH (PIC_W_MB),
    .AW    (MB_X_BITS),
    .DW    (64)
  ) u_line_ram (
    .clk     (clk),
    .we_i    (ramWe),
    .addr_i  (ramAddr),
    .wdata_i (ramWdata),
    .rdata_o (ramRdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mbX_q      <= '0;
      ready_q    <= 1'b0;
      lumaCurr_q <= '0;
      cbCurr_q   <= '0;
      crCurr_q   <= '0;
      lumaUp_q   <= '0;
      cbUp_q     <= '0;
      crUp_q     <= '0;
      lumaLeft_q <= '0;
      cbLeft_q   <= '0;
      crLeft_q   <= '0;
    end else begin
      lumaCurr_q <= lumaCurr_d;
      cbCurr_q   <= cbCurr_d;
      crCurr_q   <= crCurr_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.mb_start_in) begin
            mbX_q   <= bus.mb_x_in;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          {crUp_q, cbUp_q, lumaUp_q} <= ramRdata;
          ready_q                    <= 1'b1;
          state_q                    <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (bus.mb_done_in) begin
            ready_q <= 1'b0;
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          lumaLeft_q <= pickLuma(lumaCurr_q, LUMA_LEFT_IDX);
          cbLeft_q   <= pickChroma(cbCurr_q, CHROMA_LEFT_IDX);
          crLeft_q   <= pickChroma(crCurr_q, CHROMA_LEFT_IDX);
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (bus.start_of_pic_in) begin
        lumaLeft_q <= '0;
        cbLeft_q   <= '0;
        crLeft_q   <= '0;
      end
    end
  end

  assign bus.ready_out         = ready_q;
  assign bus.nC_up_mb_out      = lumaUp_q;
  assign bus.nC_left_mb_out    = lumaLeft_q;
  assign bus.nC_curr_mb_out    = lumaCurr_q;
  assign bus.nC_cb_up_mb_out   = cbUp_q;
  assign bus.nC_cr_up_mb_out   = crUp_q;
  assign bus.nC_cb_left_mb_out = cbLeft_q;
  assign bus.nC_cr_left_mb_out = crLeft_q;
  assign bus.nC_cb_curr_mb_out = cbCurr_q;
  assign bus.nC_cr_curr_mb_out = crCurr_q;

endmodule

// File: tb/tb_nc_store.sv
// Bench for nc_store: randomized TotalCoeff traffic compared against a per-block model
// of the current MB, left column and line buffer.
module tb_nc_store;
  import nc_store_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nc_store_if bus ();

  nc_store #(.PIC_W_MB(120)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  mLuma [16];
  logic [7:0]  mCb [4];
  logic [7:0]  mCr [4];
  logic [63:0] mLine [120];
  bit          mLineValid [120];
  logic [63:0] mUp;
  logic [63:0] mLeft;
  bit          mUpKnown;
  int          curX;

  // Model views: {cr, cb, luma} for curr; {cr, cb, luma} for up/left words
  function automatic logic [191:0] currWord();
    logic [191:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = mLuma[i];
    for (int i = 0; i < 4; i++) begin
      r[128 + 8*i +: 8] = mCb[i];
      r[160 + 8*i +: 8] = mCr[i];
    end
    return r;
  endfunction

  function automatic logic [63:0] upWord();
    return {mCr[3], mCr[2], mCb[3], mCb[2], mLuma[15], mLuma[14], mLuma[11], mLuma[10]};
  endfunction

  function automatic logic [63:0] leftWord();
    return {mCr[3], mCr[1], mCb[3], mCb[1], mLuma[15], mLuma[13], mLuma[7], mLuma[5]};
  endfunction

  function automatic logic [191:0] dutCurr();
    return {bus.nC_cr_curr_mb_out, bus.nC_cb_curr_mb_out, bus.nC_curr_mb_out};
  endfunction

  function automatic logic [63:0] dutUp();
    return {bus.nC_cr_up_mb_out, bus.nC_cb_up_mb_out, bus.nC_up_mb_out};
  endfunction

  function automatic logic [63:0] dutLeft();
    return {bus.nC_cr_left_mb_out, bus.nC_cb_left_mb_out, bus.nC_left_mb_out};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.start_of_pic_in = 1'b0;
    bus.mb_start_in     = 1'b0;
    bus.mb_x_in         = '0;
    bus.wr_en_in        = 1'b0;
    bus.wr_comp_in      = 2'd0;
    bus.wr_blk_idx_in   = 4'd0;
    bus.total_coeff_in  = 5'd0;
    bus.mb_clear_in     = 1'b0;
    bus.mb_done_in      = 1'b0;
  endtask

  task automatic zeroCurrModel();
    for (int i = 0; i < 16; i++) mLuma[i] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      mCb[i] = 8'd0;
      mCr[i] = 8'd0;
    end
  endtask

  task automatic modelWrite(input int comp, input int blk, input int val, input bit clr);
    if (clr) zeroCurrModel();
    case (comp)
      0: mLuma[blk] = val[7:0];
      1: mCb[blk % 4] = val[7:0];
      2: mCr[blk % 4] = val[7:0];
      default: ;
    endcase
  endtask

  task automatic driveWrite(input int comp, input int blk, input int val);
    bus.wr_en_in       = 1'b1;
    bus.wr_comp_in     = 2'(comp);
    bus.wr_blk_idx_in  = 4'(blk);
    bus.total_coeff_in = 5'(val);
  endtask

  task automatic startMb(input int x);
    bus.mb_start_in = 1'b1;
    bus.mb_x_in     = MB_X_BITS'(x);
    step();
    bus.mb_start_in = 1'b0;
    zeroCurrModel();
    curX     = x;
    mUpKnown = mLineValid[x];
    mUp      = mLine[x];
    step();
  endtask

  task automatic writeEntry(input int comp, input int blk, input int val, input bit clr);
    driveWrite(comp, blk, val);
    bus.mb_clear_in = clr;
    modelWrite(comp, blk, val, clr);
    step();
    bus.wr_en_in    = 1'b0;
    bus.mb_clear_in = 1'b0;
  endtask

  task automatic commitModel(input bit sop);
    mLine[curX]      = upWord();
    mLineValid[curX] = 1'b1;
    mLeft            = sop ? 64'd0 : leftWord();
  endtask

  task automatic doneMb(input bit wr, input int comp, input int blk, input int val, input bit sop);
    bus.mb_done_in = 1'b1;
    if (wr) begin
      driveWrite(comp, blk, val);
      modelWrite(comp, blk, val, 1'b0);
    end
    step();
    bus.mb_done_in      = 1'b0;
    bus.wr_en_in        = 1'b0;
    bus.start_of_pic_in = sop;
    commitModel(sop);
    step();
    bus.start_of_pic_in = 1'b0;
  endtask

  task automatic randomWrites(input int n);
    for (int i = 0; i < n; i++)
      writeEntry($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 16),
                 $urandom_range(0, 7) == 0);
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    zeroCurrModel();
    mUp = 64'd0;
    mUpKnown = 1'b1;
    mLeft = 64'd0;
    step();
    compared++;
    if (bus.ready_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got %0b want 0", bus.ready_out);
    end
    compared++;
    if (dutCurr() !== currWord()) begin
      mismatched++;
      $display("[TB] FAIL reset_curr: got %h want %h", dutCurr(), currWord());
    end
    compared++;
    if (dutUp() !== 64'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_up: got %h want 0", dutUp());
    end
    compared++;
    if (dutLeft() !== 64'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_left: got %h want 0", dutLeft());
    end
    driveWrite(0, 3, 7);
    bus.mb_clear_in = 1'b1;
    bus.mb_done_in  = 1'b1;
    step();
    clearInputs();
    step();
    compared++;
    if (bus.ready_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_stray_ready: got %0b want 0", bus.ready_out);
    end
    compared++;
    if (dutCurr() !== currWord()) begin
      mismatched++;
      $display("[TB] FAIL idle_stray_curr: got %h want %h", dutCurr(), currWord());
    end
  endtask

  task automatic test_mb_x0();
    bus.start_of_pic_in = 1'b1;
    step();
    bus.start_of_pic_in = 1'b0;
    mLeft = 64'd0;
    startMb(0);
    compared++;
    if (bus.ready_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL x0_ready: got %0b want 1", bus.ready_out);
    end
    for (int i = 0; i < 16; i++) begin
      writeEntry(0, i, i + 1, 1'b0);
      compared++;
      if (dutCurr() !== currWord()) begin
        mismatched++;
        $display("[TB] FAIL x0_write_%0d: got %h want %h", i, dutCurr(), currWord());
      end
    end
    compared++;
    if (bus.nC_curr_mb_out !== 128'h100F0E0D_0C0B0A09_08070605_04030201) begin
      mismatched++;
      $display("[TB] FAIL x0_curr_const: got %h want 100f0e0d0c0b0a090807060504030201",
               bus.nC_curr_mb_out);
    end
    doneMb(1'b0, 0, 0, 0, 1'b0);
    startMb(1);
    compared++;
    if (bus.nC_left_mb_out !== 32'h100E0806) begin
      mismatched++;
      $display("[TB] FAIL x1_left_const: got %h want 100e0806", bus.nC_left_mb_out);
    end
    compared++;
    if (dutLeft() !== mLeft) begin
      mismatched++;
      $display("[TB] FAIL x1_left_model: got %h want %h", dutLeft(), mLeft);
    end
    doneMb(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_next_row();
    startMb(0);
    compared++;
    if (bus.nC_up_mb_out !== 32'h100F0C0B) begin
      mismatched++;
      $display("[TB] FAIL row1_up_const: got %h want 100f0c0b", bus.nC_up_mb_out);
    end
    compared++;
    if (dutUp() !== mUp) begin
      mismatched++;
      $display("[TB] FAIL row1_up_model: got %h want %h", dutUp(), mUp);
    end
    writeEntry(1, 2, 4, 1'b0);
    writeEntry(1, 3, 9, 1'b0);
    doneMb(1'b0, 0, 0, 0, 1'b0);
    startMb(0);
    compared++;
    if (bus.nC_cb_up_mb_out !== 16'h0904) begin
      mismatched++;
      $display("[TB] FAIL row2_cb_up_const: got %h want 0904", bus.nC_cb_up_mb_out);
    end
    compared++;
    if (dutUp() !== mUp) begin
      mismatched++;
      $display("[TB] FAIL row2_up_model: got %h want %h", dutUp(), mUp);
    end
    doneMb(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_clear_write();
    startMb(2);
    randomWrites(6);
    writeEntry(0, 5, 7, 1'b1);
    compared++;
    if (dutCurr() !== (192'd7 << 40)) begin
      mismatched++;
      $display("[TB] FAIL clear_write_const: got %h want only blk5=7", dutCurr());
    end
    compared++;
    if (dutCurr() !== currWord()) begin
      mismatched++;
      $display("[TB] FAIL clear_write_model: got %h want %h", dutCurr(), currWord());
    end
    doneMb(1'b1, 0, 15, 3, 1'b0);
    startMb(2);
    compared++;
    if (bus.nC_up_mb_out[31:24] !== 8'd3) begin
      mismatched++;
      $display("[TB] FAIL done_write_up: got %h want 03", bus.nC_up_mb_out[31:24]);
    end
    compared++;
    if (dutUp() !== mUp) begin
      mismatched++;
      $display("[TB] FAIL done_write_model: got %h want %h", dutUp(), mUp);
    end
    doneMb(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_ignored();
    startMb(3);
    randomWrites(5);
    writeEntry(0, 0, 12, 1'b0);
    doneMb(1'b0, 0, 0, 0, 1'b0);
    driveWrite(0, 0, 1);
    bus.mb_clear_in = 1'b1;
    bus.mb_done_in  = 1'b1;
    step();
    clearInputs();
    compared++;
    if (dutCurr() !== currWord()) begin
      mismatched++;
      $display("[TB] FAIL ign_idle_curr: got %h want %h", dutCurr(), currWord());
    end
    bus.mb_start_in = 1'b1;
    bus.mb_x_in     = MB_X_BITS'(4);
    step();
    bus.mb_start_in = 1'b0;
    zeroCurrModel();
    curX     = 4;
    mUpKnown = mLineValid[4];
    mUp      = mLine[4];
    compared++;
    if (bus.ready_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ign_fetch_ready: got %0b want 0", bus.ready_out);
    end
    driveWrite(0, 1, 5);
    bus.mb_done_in = 1'b1;
    step();
    clearInputs();
    compared++;
    if (bus.ready_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL ign_active_ready: got %0b want 1", bus.ready_out);
    end
    compared++;
    if (dutCurr() !== currWord()) begin
      mismatched++;
      $display("[TB] FAIL ign_fetch_write: got %h want %h", dutCurr(), currWord());
    end
    writeEntry(3, 2, 9, 1'b0);
    compared++;
    if (dutCurr() !== currWord()) begin
      mismatched++;
      $display("[TB] FAIL ign_rsvd_comp: got %h want %h", dutCurr(), currWord());
    end
    bus.mb_start_in = 1'b1;
    bus.mb_x_in     = MB_X_BITS'(9);
    step();
    clearInputs();
    compared++;
    if (bus.ready_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL ign_start_active: got %0b want 1", bus.ready_out);
    end
    randomWrites(3);
    writeEntry(0, 15, 16, 1'b0);
    doneMb(1'b0, 0, 0, 0, 1'b0);
    startMb(4);
    compared++;
    if (dutUp() !== mUp) begin
      mismatched++;
      $display("[TB] FAIL ign_latched_x: got %h want %h", dutUp(), mUp);
    end
    doneMb(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_start_of_pic();
    startMb(5);
    writeEntry(0, 15, 9, 1'b0);
    writeEntry(2, 3, 4, 1'b0);
    doneMb(1'b0, 0, 0, 0, 1'b1);
    startMb(6);
    compared++;
    if (dutLeft() !== 64'd0) begin
      mismatched++;
      $display("[TB] FAIL sop_commit_left: got %h want 0", dutLeft());
    end
    writeEntry(0, 13, 4, 1'b0);
    doneMb(1'b0, 0, 0, 0, 1'b0);
    startMb(7);
    compared++;
    if (dutLeft() !== mLeft) begin
      mismatched++;
      $display("[TB] FAIL sop_left_load: got %h want %h", dutLeft(), mLeft);
    end
    bus.start_of_pic_in = 1'b1;
    step();
    bus.start_of_pic_in = 1'b0;
    mLeft = 64'd0;
    compared++;
    if (dutLeft() !== mLeft) begin
      mismatched++;
      $display("[TB] FAIL sop_active_left: got %h want %h", dutLeft(), mLeft);
    end
    doneMb(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int c, b, v;
    for (int k = 0; k < 10; k++) begin
      bus.mb_start_in = 1'b1;
      bus.mb_x_in     = MB_X_BITS'(10 + k);
      step();
      bus.mb_start_in = 1'b0;
      zeroCurrModel();
      curX     = 10 + k;
      mUpKnown = mLineValid[10 + k];
      mUp      = mLine[10 + k];
      compared++;
      if (bus.ready_out !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL b2b_ready_fetch_%0d: got %0b want 0", k, bus.ready_out);
      end
      step();
      compared++;
      if (bus.ready_out !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL b2b_ready_active_%0d: got %0b want 1", k, bus.ready_out);
      end
      compared++;
      if (dutLeft() !== mLeft) begin
        mismatched++;
        $display("[TB] FAIL b2b_left_%0d: got %h want %h", k, dutLeft(), mLeft);
      end
      randomWrites(1 + $urandom_range(0, 3));
      compared++;
      if (dutCurr() !== currWord()) begin
        mismatched++;
        $display("[TB] FAIL b2b_curr_%0d: got %h want %h", k, dutCurr(), currWord());
      end
      bus.mb_done_in = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        c = $urandom_range(0, 2);
        b = $urandom_range(0, 15);
        v = $urandom_range(0, 16);
        driveWrite(c, b, v);
        modelWrite(c, b, v, 1'b0);
      end
      step();
      clearInputs();
      commitModel(1'b0);
      compared++;
      if (bus.ready_out !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL b2b_ready_commit_%0d: got %0b want 0", k, bus.ready_out);
      end
      step();
      compared++;
      if (bus.ready_out !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL b2b_ready_idle_%0d: got %0b want 0", k, bus.ready_out);
      end
    end
  endtask

  task automatic test_reset_mid_mb();
    startMb(12);
    compared++;
    if (dutUp() !== mUp) begin
      mismatched++;
      $display("[TB] FAIL rmid_up_before: got %h want %h", dutUp(), mUp);
    end
    randomWrites(3);
    writeEntry(0, 10, (mLine[12][7:0] == 8'd16) ? 15 : 16, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    zeroCurrModel();
    mUp   = 64'd0;
    mLeft = 64'd0;
    compared++;
    if (bus.ready_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rmid_ready: got %0b want 0", bus.ready_out);
    end
    compared++;
    if (dutCurr() !== currWord()) begin
      mismatched++;
      $display("[TB] FAIL rmid_curr: got %h want %h", dutCurr(), currWord());
    end
    compared++;
    if (dutUp() !== mUp) begin
      mismatched++;
      $display("[TB] FAIL rmid_up: got %h want %h", dutUp(), mUp);
    end
    compared++;
    if (dutLeft() !== mLeft) begin
      mismatched++;
      $display("[TB] FAIL rmid_left: got %h want %h", dutLeft(), mLeft);
    end
    step();
    startMb(12);
    compared++;
    if (dutUp() !== mUp) begin
      mismatched++;
      $display("[TB] FAIL rmid_no_ram_write: got %h want %h", dutUp(), mUp);
    end
    doneMb(1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    clearInputs();
    for (int i = 0; i < 120; i++) mLineValid[i] = 1'b0;
    test_reset();
    test_mb_x0();
    test_next_row();
    test_clear_write();
    test_ignored();
    test_start_of_pic();
    test_back_to_back();
    test_reset_mid_mb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/nc_store.md
# nC_store

Context writer for CAVLC nC prediction. It captures the TotalCoeff value of every luma/Cb/Cr 4x4 block as the residual parser produces it. It keeps the current macroblock's values, the right column of the previous macroblock and a one-row line buffer of bottom-row values. It presents these in the packed layout consumed by the nC prediction block. It sits between the coeff_token parser (writer side) and nC prediction (reader side).

## Interface
- MB_X_BITS, `mb_x_bits: width of macroblock column index
- PIC_W_MB, 120: line-buffer depth (max picture width in macroblocks)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start_of_pic_in  in  1  pulse; clears left-column registers
- mb_start_in  in  1  pulse; begin macroblock at mb_x_in
- mb_x_in  in  MB_X_BITS  column of the macroblock being started
- wr_en_in  in  1  write one TotalCoeff value
- wr_comp_in  in  2  0 luma, 1 Cb, 2 Cr, 3 reserved (ignored)
- wr_blk_idx_in  in  4  4x4 block index (chroma uses [1:0])
- total_coeff_in  in  5  value 0..16
- mb_clear_in  in  1  zero all current-MB entries (skipped / no residual)
- mb_done_in  in  1  pulse; commit current macroblock
- ready_out  out  1  high while writes are accepted (ACTIVE)
- nC_up_mb_out  out  32  luma bottom row of above MB
- nC_left_mb_out  out  32  luma right column of left MB
- nC_curr_mb_out  out  128  luma current MB
- nC_cb_up_mb_out, nC_cr_up_mb_out  out  16 each
- nC_cb_left_mb_out, nC_cr_left_mb_out  out  16 each
- nC_cb_curr_mb_out, nC_cr_curr_mb_out  out  32 each

## Operation
- Each entry is 8 bits and zero-extended from total_coeff_in. Entry i sits at bits [8i+7:8i].
- curr luma holds blocks 0..15 in blkIdx order. Chroma curr holds blocks 0..3.
- Up packing: luma {15,14,11,10} from MSB to LSB. Chroma {3,2}.
- Left packing: luma {15,13,7,5}. Chroma {3,1}.
- FSM has four states: IDLE, FETCH, ACTIVE, COMMIT.
- IDLE –mb_start_in→ FETCH:
  - latch mb_x_in
  - issue line-RAM read at mb_x_in
  - zero all current entries
- FETCH → ACTIVE unconditionally. RAM read data is registered into the up outputs.
- ACTIVE:
  - wr_en_in with a valid wr_comp_in updates one entry.
  - mb_clear_in zeroes all entries. When clear and write occur in the same cycle, the clear is applied first and the write lands on the cleared array.
  - mb_done_in → COMMIT. A write in the same cycle as mb_done_in is included in the commit.
- COMMIT:
  - writes the 64-bit word {cr_up, cb_up, luma_up} extracted from curr to the RAM at the latched mb_x
  - loads the left registers from the curr right column
  - → IDLE
- Events outside their state are ignored: wr_en/mb_clear/mb_done outside ACTIVE, and mb_start outside IDLE.
- start_of_pic_in zeroes the left registers in any state. If it coincides with the COMMIT left load, start_of_pic_in wins.
- The block does no availability masking. Picture-edge and slice gating is the reader's job.
- Line-RAM contents are not reset. Before the first write of a picture, RAM content is don't-care.

## Timing
- Reset: state IDLE, ready_out 0, all curr/up/left outputs 0.
- Reset mid-macroblock: abandons the macroblock with no RAM write.
- mb_start_in at cycle t:
  - up outputs valid and ready_out = 1 from t+2
  - curr zeroed at t+1
- Write at cycle t is visible on nC_*_curr_mb_out at t+1.
- mb_done_in at t: RAM write and left-register update happen at t+1. ready_out drops at t+1.
- Earliest next mb_start_in is t+2. Back-to-back throughput overhead is 3 cycles per macroblock.
- Same-column readback: commit at t+1, then a fetch of the same mb_x returns the new data.

## Structure
- defines.v holds:
  - `mb_x_bits
  - component codes (luma/Cb/Cr)
  - pack index lists for up/left extraction
- Sub-module nC_line_ram: single-port synchronous RAM, 64 bits x PIC_W_MB, 1-cycle read latency, write-first.
- Top level holds the FSM, curr arrays, left registers and pack/unpack muxing.

## Test plan
- Reset, then idle: all outputs 0 and ready_out 0. Assert rst during ACTIVE → next cycle IDLE with outputs 0; a later fetch shows no RAM write occurred.
- MB at x=0:
  - write luma blk i value i+1 for i=0..15, then mb_done
  - then start MB at x=1 → left_out = {16,14,8,6} from MSB to LSB (0x100E0806)
- Next row, x=0 → nC_up_mb_out = {16,15,12,11} from MSB to LSB (0x100F0C0B). Chroma Cb blk2=4, blk3=9 → cb_up = 0x0904.
- Write blk 5 = 7 together with mb_clear_in → curr has only entry 5 = 7. mb_done in the same cycle as a write of blk15 = 3 → committed up[31:24] = 3.
- Writes with ready_out=0 and wr_comp_in=3 → no change. mb_start during ACTIVE → ignored.
- start_of_pic_in coincident with COMMIT → left_out 0. Check the 3-cycle mb_done→ready spacing over 10 consecutive MBs.
